// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions/interrupts, performs
// trap entry and MRET, owns mstatus/mie/mip/mtvec/mepc/mcause/mtval, and
// issues a registered front-end redirect over a valid/ready handshake.
// Ports:
//   clk, rst                     clock, async active-high reset
//   exc_*                        committing exception (valid/code/pc/tval)
//   exc_ready                    trap/retire inputs accepted (IDLE)
//   ret_valid, ret_pc_next       clean retire = interrupt boundary
//   mret_valid                   MRET committing
//   irq_msi/mti/mei, irq_local   level-sensitive interrupt lines
//   csr_we/addr/wdata            CSR write port
//   csr_rdata, csr_hit           combinational CSR read / address ownership
//   priv                         current privilege (3=M, 0=U)
//   redirect_valid/pc/ready      front-end redirect handshake
module trap_ctrl #(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     NUM_LOCAL_IRQ = 0,
  parameter bit              VECTORED      = 1'b1,
  parameter logic [XLEN-1:0] RESET_TVEC    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exc_valid,
  input  logic [4:0]           exc_code,
  input  logic [XLEN-1:0]      exc_pc,
  input  logic [XLEN-1:0]      exc_tval,
  output logic                 exc_ready,
  input  logic                 ret_valid,
  input  logic [XLEN-1:0]      ret_pc_next,
  input  logic                 mret_valid,
  input  logic                 irq_msi,
  input  logic                 irq_mti,
  input  logic                 irq_mei,
  input  logic [((NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1)-1:0] irq_local,
  input  logic                 csr_we,
  input  logic [11:0]          csr_addr,
  input  logic [XLEN-1:0]      csr_wdata,
  output logic [XLEN-1:0]      csr_rdata,
  output logic                 csr_hit,
  output logic [1:0]           priv,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  input  logic                 redirect_ready
);

  localparam int unsigned CLOG_CAUSE = $clog2(16 + NUM_LOCAL_IRQ);
  localparam int unsigned CAUSE_W    = (CLOG_CAUSE > 5) ? CLOG_CAUSE : 5;
  localparam logic [XLEN-1:0] MIE_MASK =
    XLEN'(((64'd1 << NUM_LOCAL_IRQ) - 64'd1) << 16) | XLEN'(64'h888);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_REDIRECT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [1:0]        priv_q, priv_d;
  logic              st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic [1:0]        st_mpp_q, st_mpp_d;
  logic [XLEN-1:0]   mie_q, mie_d;
  logic [XLEN-3:0]   tvec_base_q, tvec_base_d;
  logic              tvec_mode_q, tvec_mode_d;
  logic [XLEN-3:0]   mepc_q, mepc_d;
  logic              mcause_irq_q, mcause_irq_d;
  logic [CAUSE_W-1:0] mcause_code_q, mcause_code_d;
  logic [XLEN-1:0]   mtval_q, mtval_d;
  logic [XLEN-1:0]   rpc_q, rpc_d;

  logic [XLEN-1:0]    mip_c, pend_en_c, trap_target_c;
  logic [CAUSE_W-1:0] irq_code_c, trap_code_c;
  logic               take_irq_c, trap_irq_c;
  logic               unused_ok;

  assign unused_ok = ^{exc_pc[1:0], ret_pc_next[1:0], irq_local};

  // Live interrupt levels as seen through mip
  always_comb begin
    mip_c     = '0;
    mip_c[3]  = irq_msi;
    mip_c[7]  = irq_mti;
    mip_c[11] = irq_mei;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) mip_c[16+i] = irq_local[i];
  end

  assign pend_en_c = mip_c & mie_q;

  // Priority: MEI > MSI > MTI > highest local line (later assignments win)
  always_comb begin
    irq_code_c = '0;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++)
      if (pend_en_c[16+i]) irq_code_c = CAUSE_W'(16 + i);
    if (pend_en_c[7])  irq_code_c = CAUSE_W'(7);
    if (pend_en_c[3])  irq_code_c = CAUSE_W'(3);
    if (pend_en_c[11]) irq_code_c = CAUSE_W'(11);
  end

  // Uses registered MIE, so a same-cycle CSR write cannot mask the interrupt
  assign take_irq_c = ret_valid && ((priv_q == 2'b00) || st_mie_q) && (|pend_en_c);
  assign trap_irq_c  = !exc_valid;
  assign trap_code_c = exc_valid ? CAUSE_W'(exc_code) : irq_code_c;
  assign trap_target_c = {tvec_base_q, 2'b00} +
    ((trap_irq_c && tvec_mode_q) ? XLEN'({trap_code_c, 2'b00}) : XLEN'(0));

  // CSR read mux
  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b1;
    case (csr_addr)
      12'h300: begin
        csr_rdata[3]     = st_mie_q;
        csr_rdata[7]     = st_mpie_q;
        csr_rdata[12:11] = st_mpp_q;
      end
      12'h304: csr_rdata = mie_q;
      12'h305: csr_rdata = {tvec_base_q, 1'b0, tvec_mode_q};
      12'h341: csr_rdata = {mepc_q, 2'b00};
      12'h342: begin
        csr_rdata[XLEN-1]    = mcause_irq_q;
        csr_rdata[CAUSE_W-1:0] = mcause_code_q;
      end
      12'h343: csr_rdata = mtval_q;
      12'h344: csr_rdata = mip_c;
      default: csr_hit   = 1'b0;
    endcase
  end

  // Next state: CSR writes first, then trap/MRET overrides the fields it owns
  always_comb begin
    state_d       = state_q;
    priv_d        = priv_q;
    st_mie_d      = st_mie_q;
    st_mpie_d     = st_mpie_q;
    st_mpp_d      = st_mpp_q;
    mie_d         = mie_q;
    tvec_base_d   = tvec_base_q;
    tvec_mode_d   = tvec_mode_q;
    mepc_d        = mepc_q;
    mcause_irq_d  = mcause_irq_q;
    mcause_code_d = mcause_code_q;
    mtval_d       = mtval_q;
    rpc_d         = rpc_q;

    if (csr_we) begin
      case (csr_addr)
        12'h300: begin
          st_mie_d  = csr_wdata[3];
          st_mpie_d = csr_wdata[7];
          if (csr_wdata[12:11] == 2'b00 || csr_wdata[12:11] == 2'b11)
            st_mpp_d = csr_wdata[12:11];
        end
        12'h304: mie_d = csr_wdata & MIE_MASK;
        12'h305: begin
          tvec_base_d = csr_wdata[XLEN-1:2];
          if (!VECTORED)              tvec_mode_d = 1'b0;
          else if (!csr_wdata[1])     tvec_mode_d = csr_wdata[0];
        end
        12'h341: mepc_d = csr_wdata[XLEN-1:2];
        12'h342: begin
          mcause_irq_d  = csr_wdata[XLEN-1];
          mcause_code_d = csr_wdata[CAUSE_W-1:0];
        end
        12'h343: mtval_d = csr_wdata;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (exc_valid || take_irq_c) begin
          mepc_d        = exc_valid ? exc_pc[XLEN-1:2] : ret_pc_next[XLEN-1:2];
          mcause_irq_d  = trap_irq_c;
          mcause_code_d = trap_code_c;
          mtval_d       = exc_valid ? exc_tval : '0;
          st_mpie_d     = st_mie_q;
          st_mie_d      = 1'b0;
          st_mpp_d      = priv_q;
          priv_d        = 2'b11;
          rpc_d         = trap_target_c;
          state_d       = S_REDIRECT;
        end else if (mret_valid) begin
          st_mie_d  = st_mpie_q;
          st_mpie_d = 1'b1;
          priv_d    = st_mpp_q;
          st_mpp_d  = 2'b00;
          rpc_d     = {mepc_q, 2'b00};
          state_d   = S_REDIRECT;
        end
      end
      S_REDIRECT: if (redirect_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State and architectural register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      priv_q        <= 2'b11;
      st_mie_q      <= 1'b0;
      st_mpie_q     <= 1'b0;
      st_mpp_q      <= 2'b11;
      mie_q         <= '0;
      tvec_base_q   <= RESET_TVEC[XLEN-1:2];
      tvec_mode_q   <= 1'b0;
      mepc_q        <= '0;
      mcause_irq_q  <= 1'b0;
      mcause_code_q <= '0;
      mtval_q       <= '0;
      rpc_q         <= '0;
    end else begin
      state_q       <= state_d;
      priv_q        <= priv_d;
      st_mie_q      <= st_mie_d;
      st_mpie_q     <= st_mpie_d;
      st_mpp_q      <= st_mpp_d;
      mie_q         <= mie_d;
      tvec_base_q   <= tvec_base_d;
      tvec_mode_q   <= tvec_mode_d;
      mepc_q        <= mepc_d;
      mcause_irq_q  <= mcause_irq_d;
      mcause_code_q <= mcause_code_d;
      mtval_q       <= mtval_d;
      rpc_q         <= rpc_d;
    end
  end

  assign priv           = priv_q;
  assign redirect_valid = (state_q == S_REDIRECT);
  assign exc_ready      = (state_q == S_IDLE);
  assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus queues expected redirect targets
// and state checks; a negedge monitor pops and compares them.
module tb_trap_ctrl;

  localparam int K_CSR  = 0;
  localparam int K_PRIV = 1;
  localparam int K_RV   = 2;
  localparam int K_RPC  = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, exc_ready, ret_valid, mret_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_tval, ret_pc_next;
  logic        irq_msi, irq_mti, irq_mei;
  logic [3:0]  irq_local;
  logic        csr_we, csr_hit;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic [1:0]  priv;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;

  logic        chk_req = 1'b0;
  logic        done    = 1'b0;
  logic [31:0] redir_q[$];
  chk_t        chk_q[$];
  chk_t        c;
  logic [31:0] exp_pc, act;
  int          n_cmp = 0;
  int          n_bad = 0;

  trap_ctrl #(
    .XLEN(32), .NUM_LOCAL_IRQ(4), .VECTORED(1'b1), .RESET_TVEC(32'h0000_0107)
  ) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .exc_ready(exc_ready),
    .ret_valid(ret_valid), .ret_pc_next(ret_pc_next), .mret_valid(mret_valid),
    .irq_msi(irq_msi), .irq_mti(irq_mti), .irq_mei(irq_mei),
    .irq_local(irq_local),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_hit(csr_hit), .priv(priv),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  // Monitor: redirect handshakes, queued state checks, end-of-run summary
  always @(negedge clk) begin
    if (!rst && redirect_valid && redirect_ready) begin
      n_cmp++;
      if (redir_q.size() == 0) begin
        n_bad++;
        $display("FAIL redirect_unexpected: got 0x%08h expected none", redirect_pc);
      end else begin
        exp_pc = redir_q.pop_front();
        if (redirect_pc !== exp_pc) begin
          n_bad++;
          $display("FAIL redirect_pc: got 0x%08h expected 0x%08h", redirect_pc, exp_pc);
        end
      end
    end
    if (chk_req && chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.kind)
        K_CSR:   act = csr_rdata;
        K_PRIV:  act = 32'(priv);
        K_RV:    act = 32'({redirect_valid, exc_ready});
        default: act = redirect_pc;
      endcase
      n_cmp++;
      if (act !== c.val) begin
        n_bad++;
        $display("FAIL chk_kind%0d_addr%03h: got 0x%08h expected 0x%08h",
                 c.kind, csr_addr, act, c.val);
      end
    end
    if (done) begin
      n_cmp++;
      if (redir_q.size() != 0) begin
        n_bad++;
        $display("FAIL redirect_missing: got %0d pending expected 0", redir_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    exc_valid = 0; exc_code = '0; exc_pc = '0; exc_tval = '0;
    ret_valid = 0; ret_pc_next = '0; mret_valid = 0;
    csr_we = 0; csr_wdata = '0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1; csr_addr = a; csr_wdata = d;
    step();
    csr_we = 0;
  endtask

  task automatic chk(input int kind, input logic [31:0] v);
    chk_t e;
    e.kind = kind; e.val = v;
    chk_q.push_back(e);
    chk_req = 1;
    step();
    chk_req = 0;
  endtask

  task automatic chk_csr(input logic [11:0] a, input logic [31:0] v);
    csr_addr = a;
    chk(K_CSR, v);
  endtask

  task automatic accept();
    redirect_ready = 1;
    step();
    redirect_ready = 0;
  endtask

  initial begin
    rst = 1; redirect_ready = 0; csr_addr = '0;
    irq_msi = 0; irq_mti = 0; irq_mei = 0; irq_local = '0;
    clear_in();
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset state
    chk_csr(12'h300, 32'h0000_1800);
    chk_csr(12'h305, 32'h0000_0104);
    chk_csr(12'h341, 32'h0);
    chk(K_PRIV, 32'd3);
    chk(K_RV, 32'b01);

    // Synchronous exception, redirect held while not ready
    csr_write(12'h305, 32'h100);
    csr_write(12'h300, 32'h1808);
    exc_valid = 1; exc_code = 5'd2; exc_pc = 32'h80; exc_tval = 32'hDEAD;
    redir_q.push_back(32'h100);
    step();
    clear_in();
    chk(K_RV, 32'b10);
    chk(K_RPC, 32'h100);
    chk(K_RV, 32'b10);
    chk_csr(12'h341, 32'h80);
    chk_csr(12'h342, 32'h2);
    chk_csr(12'h343, 32'hDEAD);
    chk_csr(12'h300, 32'h1880);
    accept();
    chk(K_RV, 32'b01);

    // Vectored interrupt, MEI beats MTI
    csr_write(12'h305, 32'h201);
    csr_write(12'h304, 32'h880);
    csr_write(12'h300, 32'h1808);
    irq_mti = 1; irq_mei = 1;
    chk_csr(12'h344, 32'h880);
    ret_valid = 1; ret_pc_next = 32'h44;
    redir_q.push_back(32'h22C);
    step();
    clear_in(); irq_mti = 0; irq_mei = 0;
    chk_csr(12'h342, 32'h8000_000B);
    chk_csr(12'h341, 32'h44);
    chk_csr(12'h343, 32'h0);
    chk(K_RPC, 32'h22C);
    accept();

    // MRET to U-mode, then illegal MPP write
    csr_write(12'h300, 32'h0080);
    mret_valid = 1;
    redir_q.push_back(32'h44);
    step();
    clear_in();
    chk(K_PRIV, 32'd0);
    chk_csr(12'h300, 32'h88);
    accept();
    csr_write(12'h300, 32'h0888);
    chk_csr(12'h300, 32'h88);

    // Local interrupt taken in U-mode with MIE=0
    csr_write(12'h300, 32'h0080);
    csr_write(12'h304, 32'hFFFF_FFFF);
    chk_csr(12'h304, 32'h000F_0888);
    csr_write(12'h304, 32'h0004_0000);
    irq_local = 4'b0100;
    ret_valid = 1; ret_pc_next = 32'h1236;
    redir_q.push_back(32'h248);
    step();
    clear_in(); irq_local = '0;
    chk_csr(12'h342, 32'h8000_0012);
    chk_csr(12'h341, 32'h1234);
    chk(K_PRIV, 32'd3);
    chk_csr(12'h300, 32'h0);
    accept();

    // MODE=2 write keeps old mode; exception beats MRET, ignores vectoring
    csr_write(12'h305, 32'h301);
    csr_write(12'h305, 32'h402);
    chk_csr(12'h305, 32'h401);
    exc_valid = 1; exc_code = 5'd5; exc_pc = 32'h90; exc_tval = 32'h11;
    mret_valid = 1;
    redir_q.push_back(32'h400);
    step();
    clear_in();
    chk_csr(12'h342, 32'h5);
    chk_csr(12'h341, 32'h90);
    chk_csr(12'h300, 32'h1800);
    chk(K_PRIV, 32'd3);
    accept();

    // Reset while a redirect is pending
    exc_valid = 1; exc_code = 5'd3; exc_pc = 32'hA0; exc_tval = 32'h1;
    step();
    clear_in();
    chk(K_RV, 32'b10);
    rst = 1;
    step();
    rst = 0;
    chk(K_RV, 32'b01);
    chk(K_RPC, 32'h0);
    chk_csr(12'h300, 32'h1800);
    chk_csr(12'h305, 32'h104);
    chk_csr(12'h304, 32'h0);
    chk_csr(12'h341, 32'h0);
    chk_csr(12'h342, 32'h0);
    chk_csr(12'h343, 32'h0);
    chk(K_PRIV, 32'd3);

    done = 1;
  end

endmodule
